// File: rtl/regfile_wb_arbiter.sv
// -----------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Arbitrates two writeback sources (ALU and load unit) onto the single
// register-file write port. It also keeps a pending-write scoreboard that
// decode uses for WAW stalls and operand hazard queries.
//
// Ports
//   clk          single clock, all state changes on the rising edge
//   rst_n        synchronous active-low reset
//   alu_valid/alu_rd/alu_data, alu_ready   ALU writeback request channel
//   lsu_valid/lsu_rd/lsu_data, lsu_ready   load-unit writeback request channel
//   wr_en/wr_rd/wr_data                    registered register-file write port
//   issue_valid/issue_rd, issue_ready      decode marks rd as pending-write
//   q_rs1/q_rs2, busy_rs1/busy_rs2         combinational hazard query
//
// Behaviour summary
//   - At most one channel is granted per cycle. When both channels are valid,
//     the channel that was not granted most recently wins.
//   - A grant at edge N appears on the write port throughout cycle N+1.
//     A grant to x0 is accepted but never produces a write.
//   - busy[r] is set when decode issues a write to r and cleared when the
//     write to r leaves the port. A set and a clear on the same edge leave
//     the bit set.
// -----------------------------------------------------------------------------
module regfile_wb_arbiter (
  input  logic        clk,
  input  logic        rst_n,

  input  logic        alu_valid,
  input  logic [4:0]  alu_rd,
  input  logic [31:0] alu_data,
  output logic        alu_ready,

  input  logic        lsu_valid,
  input  logic [4:0]  lsu_rd,
  input  logic [31:0] lsu_data,
  output logic        lsu_ready,

  output logic        wr_en,
  output logic [4:0]  wr_rd,
  output logic [31:0] wr_data,

  input  logic        issue_valid,
  input  logic [4:0]  issue_rd,
  output logic        issue_ready,

  input  logic [4:0]  q_rs1,
  input  logic [4:0]  q_rs2,
  output logic        busy_rs1,
  output logic        busy_rs2
);

  // Which channel won the most recent grant. Reset value LAST_ALU makes the
  // LSU win the first conflict.
  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_LSU = 1'b1
  } last_grant_e;

  last_grant_e last_grant_q, last_grant_d;

  logic        alu_grant;
  logic        lsu_grant;
  logic [4:0]  sel_rd;
  logic [31:0] sel_data;
  logic        wr_en_d;

  logic [31:1] busy_q;
  logic [31:1] busy_d;
  logic [31:0] busy_vec;       // busy_q with a constant-0 entry for x0
  logic [31:0] busy_next_vec;
  logic        issue_fire;

  // ---------------------------------------------------------------------------
  // Arbitration (combinational). The write port drains every cycle, so
  // readiness depends only on the valid inputs, the pointer and reset.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves
    // a variable unassigned, which would otherwise infer a latch.
    alu_grant    = 1'b0;
    lsu_grant    = 1'b0;
    last_grant_d = last_grant_q;

    if (rst_n) begin
      if (alu_valid && lsu_valid) begin
        if (last_grant_q == LAST_LSU) alu_grant = 1'b1;
        else                          lsu_grant = 1'b1;
      end else begin
        alu_grant = alu_valid;
        lsu_grant = lsu_valid;
      end
    end

    // The pointer moves only when something is actually granted.
    if (alu_grant)      last_grant_d = LAST_ALU;
    else if (lsu_grant) last_grant_d = LAST_LSU;
  end

  assign alu_ready = alu_grant;
  assign lsu_ready = lsu_grant;

  // Write-port source select. An x0 grant is consumed but never writes.
  always_comb begin
    sel_rd   = 5'd0;
    sel_data = 32'd0;
    if (alu_grant) begin
      sel_rd   = alu_rd;
      sel_data = alu_data;
    end else if (lsu_grant) begin
      sel_rd   = lsu_rd;
      sel_data = lsu_data;
    end
  end

  assign wr_en_d = (alu_grant || lsu_grant) && (sel_rd != 5'd0);

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  assign busy_vec = {busy_q, 1'b0};

  // busy_vec[0] is constant 0, so x0 never stalls issue.
  assign issue_ready = rst_n && !busy_vec[issue_rd];
  assign issue_fire  = issue_valid && issue_ready && (issue_rd != 5'd0);

  assign busy_rs1 = busy_vec[q_rs1];
  assign busy_rs2 = busy_vec[q_rs2];

  always_comb begin
    busy_next_vec = busy_vec;
    // The clear is applied before the set, so a same-edge set of the same
    // index wins.
    if (wr_en)      busy_next_vec[wr_rd]    = 1'b0;
    if (issue_fire) busy_next_vec[issue_rd] = 1'b1;
    busy_d = busy_next_vec[31:1];
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, whatever the order of the statements.
    if (!rst_n) begin
      // NOTE: the scoreboard flops are reset explicitly. A reset must drop
      // every pending write, and stale busy bits would stall decode forever.
      wr_en        <= 1'b0;
      wr_rd        <= 5'd0;
      wr_data      <= 32'd0;
      last_grant_q <= LAST_ALU;
      busy_q       <= '0;
    end else begin
      wr_en        <= wr_en_d;
      last_grant_q <= last_grant_d;
      busy_q       <= busy_d;
      // Address and data are only meaningful while wr_en is high. They are
      // loaded on every grant and otherwise hold.
      if (alu_grant || lsu_grant) begin
        wr_rd   <= sel_rd;
        wr_data <= sel_data;
      end
    end
  end

endmodule
